// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - GF(2^8) and RS(255,239) constants shared by the syndrome calculator
package rs_pkg;
    localparam logic [8:0] GF_POLY  = 9'h11D;
    localparam logic [7:0] GF_ALPHA = 8'h02;
    localparam int         RS_N     = 255;
    localparam int         RS_K     = 239;
    localparam int         RS_NSYM  = 16;

    // alpha^j for the syndrome roots alpha^0..alpha^15
    localparam logic [7:0] ALPHA_POW [0:15] = '{
        8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
        8'h1D, 8'h3A, 8'h74, 8'hE8, 8'hCD, 8'h87, 8'h13, 8'h26
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } syn_state_t;
endpackage

// File: rtl/gf2_8_mul.sv
// rtl/gf2_8_mul.sv - combinational GF(2^8) multiplier modulo GF_POLY
module gf2_8_mul
    import rs_pkg::*;
(
    input  logic [7:0] i_a,
    input  logic [7:0] i_b,
    output logic [7:0] o_p
);
    logic [7:0] w_sh;
    logic [7:0] w_p;

    // shift-and-add; with i_b tied to a constant this folds to an XOR network
    always_comb begin
        w_p  = 8'h00;
        w_sh = i_a;
        for (int i = 0; i < 8; i++) begin
            if (i_b[i]) begin
                w_p = w_p ^ w_sh;
            end
            w_sh = {w_sh[6:0], 1'b0} ^ (w_sh[7] ? GF_POLY[7:0] : 8'h00);
        end
    end

    assign o_p = w_p;
endmodule

// File: rtl/rs_syn_cell.sv
// rtl/rs_syn_cell.sv - one Horner accumulator evaluating the codeword at alpha^J
module rs_syn_cell
    import rs_pkg::*;
#(
    parameter int J = 0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_acc,
    input  logic [7:0] i_din,
    output logic [7:0] o_nxt
);
    logic [7:0] r_acc;
    logic [7:0] w_mul;

    generate
        if (J == 0) begin : g_root_one
            assign w_mul = r_acc;
        end else begin : g_root_mul
            gf2_8_mul u_mul (
                .i_a (r_acc),
                .i_b (ALPHA_POW[J]),
                .o_p (w_mul)
            );
        end
    endgenerate

    // o_nxt is the value the accumulator takes on this beat; the top latches it at eop
    assign o_nxt = i_load ? i_din : (w_mul ^ i_din);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= 8'h00;
        end else if (i_load || i_acc) begin
            r_acc <= o_nxt;
        end
    end
endmodule

// File: rtl/rs_syndrome_calc.sv
// rtl/rs_syndrome_calc.sv - streaming RS(255,239) syndrome calculator; SYN_LEN_CHECK_EN adds len_err
module rs_syndrome_calc
    import rs_pkg::*;
#(
    parameter int NSYM = RS_NSYM
`ifdef SYN_LEN_CHECK_EN
    ,
    parameter int N    = RS_N
`endif
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              din_valid,
    input  logic              din_sop,
    input  logic              din_eop,
    input  logic [7:0]        din,
    output logic              syn_valid,
    output logic [8*NSYM-1:0] syn_out,
    output logic              syn_nz,
`ifdef SYN_LEN_CHECK_EN
    output logic              len_err,
`endif
    output logic              busy
);
    syn_state_t        r_state;
    syn_state_t        w_state_nxt;
    logic              w_load;
    logic              w_acc;
    logic              w_emit;
    logic [8*NSYM-1:0] w_nxt;
    logic              r_syn_valid;
    logic [8*NSYM-1:0] r_syn_out;
    logic              r_syn_nz;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // a sop in any state restarts the codeword, dropping the partial one
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_acc       = 1'b0;
        w_emit      = 1'b0;
        if (din_valid && din_sop) begin
            w_load      = 1'b1;
            w_emit      = din_eop;
            w_state_nxt = din_eop ? ST_IDLE : ST_ACC;
        end else if (din_valid && (r_state == ST_ACC)) begin
            w_acc  = 1'b1;
            w_emit = din_eop;
            if (din_eop) begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    generate
        for (genvar j = 0; j < NSYM; j++) begin : g_cell
            rs_syn_cell #(.J(j)) u_cell (
                .i_clk  (sys_clk),
                .i_rst  (sys_rst),
                .i_load (w_load),
                .i_acc  (w_acc),
                .i_din  (din),
                .o_nxt  (w_nxt[8*j +: 8])
            );
        end
    endgenerate

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_syn_valid <= 1'b0;
            r_syn_out   <= '0;
            r_syn_nz    <= 1'b0;
        end else begin
            r_syn_valid <= w_emit;
            if (w_emit) begin
                r_syn_out <= w_nxt;
                r_syn_nz  <= |w_nxt;
            end
        end
    end

`ifdef SYN_LEN_CHECK_EN
    localparam logic [8:0] LEN_N = 9'(N);

    logic [7:0] r_cnt;
    logic       r_ovf;
    logic       r_len_err;
    logic [8:0] w_cnt_inc;
    logic       w_len_bad;

    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
    assign w_len_bad = w_load ? (LEN_N != 9'd1) : (r_ovf || (w_cnt_inc != LEN_N));

    // r_ovf remembers that the count ran past N, since the 8-bit counter wraps
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_cnt     <= 8'd0;
            r_ovf     <= 1'b0;
            r_len_err <= 1'b0;
        end else begin
            if (w_load) begin
                r_cnt <= 8'd1;
                r_ovf <= 1'b0;
            end else if (w_acc) begin
                r_cnt <= w_cnt_inc[7:0];
                if (w_cnt_inc > LEN_N) begin
                    r_ovf <= 1'b1;
                end
            end
            if (w_emit) begin
                r_len_err <= w_len_bad;
            end
        end
    end

    assign len_err = r_len_err;
`endif

    assign syn_valid = r_syn_valid;
    assign syn_out   = r_syn_out;
    assign syn_nz    = r_syn_nz;
    assign busy      = (r_state == ST_ACC);
endmodule

// File: tb/tb_rs_syndrome_calc.sv
// tb/tb_rs_syndrome_calc.sv - directed self-checking bench for rs_syndrome_calc
module tb_rs_syndrome_calc;
    logic         sys_clk = 1'b0;
    logic         sys_rst;
    logic         din_valid;
    logic         din_sop;
    logic         din_eop;
    logic [7:0]   din;
    logic         syn_valid;
    logic [127:0] syn_out;
    logic         syn_nz;
    logic         busy;
`ifdef SYN_LEN_CHECK_EN
    logic         len_err;
`endif

    always #5 sys_clk = ~sys_clk;

    rs_syndrome_calc dut (
        .sys_clk   (sys_clk),
        .sys_rst   (sys_rst),
        .din_valid (din_valid),
        .din_sop   (din_sop),
        .din_eop   (din_eop),
        .din       (din),
        .syn_valid (syn_valid),
        .syn_out   (syn_out),
        .syn_nz    (syn_nz),
`ifdef SYN_LEN_CHECK_EN
        .len_err   (len_err),
`endif
        .busy      (busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    int           cyc = 0;
    int           n_pulse = 0;
    int           last_pulse_cyc = 0;
    int           prev_pulse_cyc = 0;
    logic [127:0] cap_out = '0;
    logic [127:0] cap_prev = '0;
    logic         cap_nz = 1'b0;
    logic         cap_len = 1'b0;

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (syn_valid) begin
            n_pulse++;
            prev_pulse_cyc = last_pulse_cyc;
            last_pulse_cyc = cyc;
            cap_prev = cap_out;
            cap_out  = syn_out;
            cap_nz   = syn_nz;
`ifdef SYN_LEN_CHECK_EN
            cap_len  = len_err;
`endif
        end
    end

    int   eop_cyc = 0;
    logic busy_mid = 1'b0;

    task automatic drive(input logic v, input logic s, input logic e, input logic [7:0] d);
        @(negedge sys_clk);
        din_valid = v;
        din_sop   = s;
        din_eop   = e;
        din       = d;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    // all-zero codeword except the first and last symbols
    task automatic send_cw(input int len, input logic [7:0] first, input logic [7:0] last, input int gap_pct);
        logic [7:0] d;
        for (int i = 0; i < len; i++) begin
            if (gap_pct > 0 && i > 0 && $urandom_range(99) < gap_pct) idle($urandom_range(1, 3));
            d = (i == 0) ? first : ((i == len - 1) ? last : 8'h00);
            drive(1'b1, i == 0, i == len - 1, d);
            if (i == 2) busy_mid = busy;
            if (i == len - 1) eop_cyc = cyc;
        end
    endtask

    logic [7:0]   inv_tab [0:15] = '{8'h01, 8'h8E, 8'h47, 8'hAD, 8'hD8, 8'h6C, 8'h36, 8'h1B,
                                     8'h83, 8'hCF, 8'hE9, 8'hFA, 8'h7D, 8'hB0, 8'h58, 8'h2C};
    logic [127:0] exp_first;
    logic [127:0] exp_ones;
    int           p0;
    int           eop_first;

    initial begin
        for (int j = 0; j < 16; j++) exp_first[8*j +: 8] = inv_tab[j];
        exp_ones  = {16{8'h01}};
        sys_rst   = 1'b1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
        din       = 8'h00;
        idle(3);
        check_eq("rst_valid", 128'(syn_valid), 128'd0);
        check_eq("rst_out", syn_out, 128'd0);
        check_eq("rst_nz", 128'(syn_nz), 128'd0);
        check_eq("rst_busy", 128'(busy), 128'd0);
        sys_rst = 1'b0;
        idle(2);

        p0 = n_pulse;
        send_cw(255, 8'h00, 8'h00, 0);
        check_eq("zero_busy_mid", 128'(busy_mid), 128'd1);
        idle(3);
        check_eq("zero_pulses", 128'(n_pulse - p0), 128'd1);
        check_eq("zero_latency", 128'(last_pulse_cyc - eop_cyc), 128'd1);
        check_eq("zero_out", cap_out, 128'd0);
        check_eq("zero_nz", 128'(cap_nz), 128'd0);
        check_eq("zero_busy_after", 128'(busy), 128'd0);
`ifdef SYN_LEN_CHECK_EN
        check_eq("zero_len_err", 128'(cap_len), 128'd0);
`endif

        p0 = n_pulse;
        send_cw(255, 8'h00, 8'h01, 0);
        idle(3);
        check_eq("last1_pulses", 128'(n_pulse - p0), 128'd1);
        check_eq("last1_out", cap_out, exp_ones);
        check_eq("last1_nz", 128'(cap_nz), 128'd1);

        p0 = n_pulse;
        send_cw(255, 8'h01, 8'h00, 0);
        idle(3);
        check_eq("first1_pulses", 128'(n_pulse - p0), 128'd1);
        check_eq("first1_out", cap_out, exp_first);
        check_eq("first1_nz", 128'(cap_nz), 128'd1);

        p0 = n_pulse;
        send_cw(255, 8'h01, 8'h00, 30);
        eop_first = eop_cyc;
        send_cw(255, 8'h00, 8'h01, 0);
        idle(3);
        check_eq("b2b_pulses", 128'(n_pulse - p0), 128'd2);
        check_eq("b2b_first_out", cap_prev, exp_first);
        check_eq("b2b_first_lat", 128'(prev_pulse_cyc - eop_first), 128'd1);
        check_eq("b2b_no_bubble", 128'(last_pulse_cyc - prev_pulse_cyc), 128'd255);
        check_eq("b2b_second_out", cap_out, exp_ones);

        p0 = n_pulse;
        send_cw(1, 8'h5A, 8'h5A, 0);
        idle(3);
        check_eq("one_sym_pulses", 128'(n_pulse - p0), 128'd1);
        check_eq("one_sym_lat", 128'(last_pulse_cyc - eop_cyc), 128'd1);
        check_eq("one_sym_out", cap_out, {16{8'h5A}});
`ifdef SYN_LEN_CHECK_EN
        check_eq("one_sym_len_err", 128'(cap_len), 128'd1);
`endif

        p0 = n_pulse;
        for (int i = 0; i < 50; i++) drive(1'b1, i == 0, 1'b0, 8'h77);
        @(negedge sys_clk);
        sys_rst   = 1'b1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        idle(2);
        check_eq("midrst_valid", 128'(syn_valid), 128'd0);
        check_eq("midrst_out", syn_out, 128'd0);
        check_eq("midrst_nz", 128'(syn_nz), 128'd0);
        check_eq("midrst_busy", 128'(busy), 128'd0);
        sys_rst = 1'b0;
        idle(2);
        check_eq("midrst_no_pulse", 128'(n_pulse - p0), 128'd0);
        send_cw(255, 8'h00, 8'h01, 0);
        idle(3);
        check_eq("midrst_clean_pulses", 128'(n_pulse - p0), 128'd1);
        check_eq("midrst_clean_out", cap_out, exp_ones);

        p0 = n_pulse;
        for (int i = 0; i < 100; i++) drive(1'b1, i == 0, 1'b0, 8'h33);
        send_cw(255, 8'h00, 8'h00, 0);
        idle(3);
        check_eq("restart_pulses", 128'(n_pulse - p0), 128'd1);
        check_eq("restart_out", cap_out, 128'd0);
        check_eq("restart_nz", 128'(cap_nz), 128'd0);

`ifdef SYN_LEN_CHECK_EN
        p0 = n_pulse;
        send_cw(254, 8'h00, 8'h00, 0);
        idle(3);
        check_eq("short_pulses", 128'(n_pulse - p0), 128'd1);
        check_eq("short_len_err", 128'(cap_len), 128'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
